// File: rtl/bus_pkg.sv
// Shared definitions for the snooping bus arbiters: board-ID width, default board
// count, data-arbiter state encoding and bus command encodings.
`default_nettype none

package bus_pkg;

    localparam int BOARD_ID_W         = 3;
    localparam int NUM_BOARDS_DEFAULT = 5;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_TENURE = 2'd2
    } data_arb_state_t;

    typedef enum logic [1:0] {
        BUS_CMD_IDLE      = 2'b00,
        BUS_CMD_RD_SHARE  = 2'b01,
        BUS_CMD_RD_OWN    = 2'b10,
        BUS_CMD_WRITEBACK = 2'b11
    } bus_cmd_t;

    // Round-robin successor of board k among n boards.
    function automatic logic [BOARD_ID_W-1:0] rr_next(input logic [BOARD_ID_W-1:0] k,
                                                      input int n);
        return (int'(k) == n - 1) ? '0 : k + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N. Shared by the address- and data-bus arbiters.
`default_nettype none

module rr_priority_picker #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_onehot_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_valid_o
);

    logic [IDX_W:0] cand;

    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        any_valid_o    = 1'b0;
        cand           = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index walks forward from the pointer and wraps at N.
            cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!any_valid_o && req_i[cand[IDX_W-1:0]]) begin
                any_valid_o                         = 1'b1;
                grant_onehot_o[cand[IDX_W-1:0]]     = 1'b1;
                grant_idx_o                         = cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_bus_arbiter.sv
// Data-bus arbiter: address/data phase generator, round-robin grant sampling in
// data-phase IDLE cycles, and a fixed post-grant tenure window.
`default_nettype none

module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_BOARDS = NUM_BOARDS_DEFAULT,
    parameter int TENURE     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BOARDS-1:0] data_bus_request,
    output logic                  addr_data_arbitration,
    output logic [NUM_BOARDS-1:0] data_bus_gain,
    output logic [BOARD_ID_W-1:0] grant_id,
    output logic                  data_bus_busy
);

    localparam int               CNT_W       = 4;
    localparam logic [CNT_W-1:0] TENURE_LOAD = CNT_W'(TENURE - 1);

    data_arb_state_t        state_q, state_d;
    logic                   phase_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BOARD_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_BOARDS-1:0]  gain_q, gain_d;
    logic [BOARD_ID_W-1:0]  grant_id_q, grant_id_d;
    logic                   busy_q, busy_d;

    logic [NUM_BOARDS-1:0]  w_pick_onehot;
    logic [BOARD_ID_W-1:0]  w_pick_idx;
    logic                   w_pick_any;
    logic                   w_take;

    rr_priority_picker #(
        .N     (NUM_BOARDS),
        .IDX_W (BOARD_ID_W)
    ) u_picker (
        .req_i          (data_bus_request),
        .ptr_i          (rr_ptr_q),
        .grant_onehot_o (w_pick_onehot),
        .grant_idx_o    (w_pick_idx),
        .any_valid_o    (w_pick_any)
    );

    // Requests count only in an IDLE data-phase cycle; nothing is latched otherwise.
    assign w_take = (state_q == ARB_IDLE) && !phase_q && w_pick_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            phase_q    <= 1'b1;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            gain_q     <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= ~phase_q;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            gain_q     <= gain_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_take) begin
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                state_d = ARB_TENURE;
                cnt_d   = TENURE_LOAD;
            end
            ARB_TENURE: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered: compute their next values from the next state.
    always_comb begin
        gain_d     = w_take ? w_pick_onehot : '0;
        grant_id_d = w_take ? w_pick_idx : grant_id_q;
        rr_ptr_d   = w_take ? rr_next(w_pick_idx, NUM_BOARDS) : rr_ptr_q;
        busy_d     = (state_d != ARB_IDLE);
    end

    assign addr_data_arbitration = phase_q;
    assign data_bus_gain         = gain_q;
    assign grant_id              = grant_id_q;
    assign data_bus_busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter (NUM_BOARDS=5, TENURE=3).
`default_nettype none

module tb_data_bus_arbiter;

    localparam int NB = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] req = '0;
    logic          phase;
    logic [NB-1:0] gain;
    logic [2:0]    gid;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    // Cycles since reset release; even = address phase, odd = data phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    data_bus_arbiter #(.NUM_BOARDS(NB), .TENURE(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_bus_request      (req),
        .addr_data_arbitration (phase),
        .data_bus_gain         (gain),
        .grant_id              (gid),
        .data_bus_busy         (busy)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NB-1:0] req_during);
        @(negedge clk);
        rst = 1'b0;
        req = req_during;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
        checks++; if (gain !== 5'b00000) begin failures++; $display("FAIL reset_gain actual=%b expected=00000", gain); end
        checks++; if (gid !== 3'd0) begin failures++; $display("FAIL reset_gid actual=%0d expected=0", gid); end
        checks++; if (phase !== 1'b1) begin failures++; $display("FAIL reset_phase actual=%0b expected=1", phase); end
        step();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (phase !== ((i % 2) == 0)) begin failures++; $display("FAIL idle_phase cyc=%0d actual=%0b expected=%0b", i, phase, ((i % 2) == 0)); end
            checks++; if (gain !== 5'b00000 || busy !== 1'b0) begin failures++; $display("FAIL idle_quiet cyc=%0d actual gain=%b busy=%0b expected gain=00000 busy=0", i, gain, busy); end
            step();
        end
    endtask

    task automatic test_single_grant();
        do_reset('0);
        step();                    // cyc 1: data phase
        req = 5'b00100;
        step();                    // cyc 2: grant cycle
        req = '0;
        checks++; if (gain !== 5'b00100) begin failures++; $display("FAIL single_gain actual=%b expected=00100", gain); end
        checks++; if (gid !== 3'd2) begin failures++; $display("FAIL single_gid actual=%0d expected=2", gid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_grant actual=%0b expected=1", busy); end
        checks++; if (phase !== 1'b1) begin failures++; $display("FAIL single_grant_phase actual=%0b expected=1", phase); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (gain !== 5'b00000 || busy !== 1'b1 || gid !== 3'd2) begin failures++; $display("FAIL single_tenure k=%0d actual gain=%b busy=%0b gid=%0d expected gain=00000 busy=1 gid=2", k, gain, busy, gid); end
        end
        step();                    // cyc 6: tenure over
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end actual=%0b expected=0", busy); end
        step();                    // cyc 7: data phase, pointer now 3
        req = 5'b01010;
        step();
        req = '0;
        checks++; if (gain !== 5'b01000 || gid !== 3'd3) begin failures++; $display("FAIL single_ptr3 actual gain=%b gid=%0d expected gain=01000 gid=3", gain, gid); end
        repeat (5) step();
    endtask

    task automatic test_round_robin();
        logic [NB-1:0] e_gain;
        logic          e_busy;
        do_reset(5'b11111);
        for (int n = 0; n < 38; n++) begin
            e_gain = '0;
            e_busy = 1'b0;
            if (n >= 2) begin
                if (((n - 2) % 6) == 0) e_gain = NB'(1) << (((n - 2) / 6) % NB);
                e_busy = (((n - 2) % 6) < 4);
            end
            checks++; if (gain !== e_gain) begin failures++; $display("FAIL rr_gain cyc=%0d actual=%b expected=%b", n, gain, e_gain); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rr_busy cyc=%0d actual=%0b expected=%0b", n, busy, e_busy); end
            if (n >= 2 && ((n - 2) % 6) == 0) begin
                checks++; if (gid !== 3'(((n - 2) / 6) % NB)) begin failures++; $display("FAIL rr_gid cyc=%0d actual=%0d expected=%0d", n, gid, ((n - 2) / 6) % NB); end
            end
            step();
        end
        req = '0;
        repeat (6) step();
    endtask

    task automatic test_ignored_requests();
        do_reset('0);
        req = 5'b10000;            // cyc 0: address phase only
        step();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (gain !== 5'b00000 || busy !== 1'b0) begin failures++; $display("FAIL addr_phase_req k=%0d actual gain=%b busy=%0b expected gain=00000 busy=0", k, gain, busy); end
            step();
        end
        req = 5'b00001;            // cyc 5: data phase
        step();
        req = 5'b10000;            // board 4 asks throughout board 0's tenure
        checks++; if (gain !== 5'b00001 || gid !== 3'd0) begin failures++; $display("FAIL ign_board0 actual gain=%b gid=%0d expected gain=00001 gid=0", gain, gid); end
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) req = '0;
            checks++; if (gain !== 5'b00000) begin failures++; $display("FAIL tenure_req k=%0d actual=%b expected=00000", k, gain); end
            step();
        end
    endtask

    task automatic test_wrap();
        do_reset('0);
        step();                    // cyc 1
        req = 5'b01000;
        step();                    // cyc 2
        req = '0;
        checks++; if (gain !== 5'b01000) begin failures++; $display("FAIL wrap_setup actual=%b expected=01000", gain); end
        repeat (5) step();         // cyc 7: data phase, pointer 4
        req = 5'b10001;
        step();                    // cyc 8
        checks++; if (gain !== 5'b10000 || gid !== 3'd4) begin failures++; $display("FAIL wrap_first actual gain=%b gid=%0d expected gain=10000 gid=4", gain, gid); end
        repeat (6) step();         // cyc 14
        checks++; if (gain !== 5'b00001 || gid !== 3'd0) begin failures++; $display("FAIL wrap_second actual gain=%b gid=%0d expected gain=00001 gid=0", gain, gid); end
        repeat (6) step();         // cyc 20
        checks++; if (gain !== 5'b10000 || gid !== 3'd4) begin failures++; $display("FAIL wrap_third actual gain=%b gid=%0d expected gain=10000 gid=4", gain, gid); end
        req = '0;
        repeat (6) step();
    endtask

    task automatic test_reset_mid_tenure();
        do_reset('0);
        step();                    // cyc 1
        req = 5'b00010;
        step();                    // cyc 2
        req = '0;
        checks++; if (gain !== 5'b00010) begin failures++; $display("FAIL mid_setup actual=%b expected=00010", gain); end
        step();                    // cyc 3: first tenure cycle
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || gain !== 5'b00000 || gid !== 3'd0 || phase !== 1'b1) begin failures++; $display("FAIL mid_reset actual busy=%0b gain=%b gid=%0d phase=%0b expected busy=0 gain=00000 gid=0 phase=1", busy, gain, gid, phase); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (phase !== 1'b1) begin failures++; $display("FAIL mid_phase_restart actual=%0b expected=1", phase); end
        step();                    // cyc 1: data phase, pointer must be 0 again
        req = 5'b10001;
        checks++; if (gain !== 5'b00000) begin failures++; $display("FAIL mid_no_pulse actual=%b expected=00000", gain); end
        step();                    // cyc 2
        req = '0;
        checks++; if (gain !== 5'b00001 || gid !== 3'd0) begin failures++; $display("FAIL mid_regrant actual gain=%b gid=%0d expected gain=00001 gid=0", gain, gid); end
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_ignored_requests();
        test_wrap();
        test_reset_mid_tenure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
